// File: rtl/control_sequencer_pkg.sv
// cpu_defs: shared CPU definitions used by the control sequencer.
// Holds the sequencer state encoding, the instruction opcodes and the
// bundle of control strobes the sequencer drives into the datapath.
package cpu_defs;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef struct packed {
    logic PCout;
    logic MARin;
    logic IncPC;
    logic PCin;
    logic Read;
    logic Write;
    logic MDRin;
    logic MDRout;
    logic IRin;
    logic Yin;
    logic Zin;
    logic Zlowout;
    logic ADD;
    logic Cout;
    logic Gra;
    logic Grb;
    logic Rin;
    logic Rout;
    logic BAout;
    logic CONin;
  } ctrl_t;

  // Number of bus drivers enabled in one strobe set; a legal state has at most one.
  function automatic logic [2:0] bus_driver_count(input ctrl_t c);
    bus_driver_count = {2'b00, c.PCout} + {2'b00, c.MDRout} + {2'b00, c.Zlowout}
                     + {2'b00, c.Rout}  + {2'b00, c.BAout}  + {2'b00, c.Cout};
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// the instruction opcode and branch condition come in, the strobes go out.
interface control_sequencer_if;
  logic [4:0] opcode;
  logic       CON;
  logic       Run;
  logic       PCout;
  logic       MARin;
  logic       IncPC;
  logic       PCin;
  logic       Read;
  logic       Write;
  logic       MDRin;
  logic       MDRout;
  logic       IRin;
  logic       Yin;
  logic       Zin;
  logic       Zlowout;
  logic       ADD;
  logic       Cout;
  logic       Gra;
  logic       Grb;
  logic       Rin;
  logic       Rout;
  logic       BAout;
  logic       CONin;

  modport master (
    input  opcode, CON,
    output Run, PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, ADD, Cout, Gra, Grb, Rin, Rout, BAout, CONin
  );

  modport slave (
    output opcode, CON,
    input  Run, PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, ADD, Cout, Gra, Grb, Rin, Rout, BAout, CONin
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch in T0-T2, opcode-qualified execute in
// T3-T7, then back to T0. HALT parks the machine until clr.
// The opcode is taken live from IR in T3 and latched at the end of T3, so
// later IR changes cannot disturb an instruction already in flight.
module control_sequencer
  import cpu_defs::*;
(
  input  logic             clk,
  input  logic             clr,
  control_sequencer_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_opcode;
  logic [4:0] w_op;
  ctrl_t      w_ctrl;
  logic       w_run;

  // In T3 decode straight from IR; from T4 on use the copy latched in T3.
  assign w_op = (r_state == S_T3) ? bus.opcode : r_opcode;

  // State register with asynchronous clear back to RST.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode latch, loaded only while the sequencer sits in T3.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_opcode <= 5'd0;
    end else if (r_state == S_T3) begin
      r_opcode <= bus.opcode;
    end else begin
      r_opcode <= r_opcode;
    end
  end

  // Next-state and strobe decode from the current state (CON only read in br T6).
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    w_run  = 1'b0;
    case (r_state)
      S_RST: begin
        w_next = S_T0;
      end
      S_T0: begin
        w_run        = 1'b1;
        w_ctrl.PCout = 1'b1;
        w_ctrl.MARin = 1'b1;
        w_ctrl.IncPC = 1'b1;
        w_next       = S_T1;
      end
      S_T1: begin
        w_run        = 1'b1;
        w_ctrl.Read  = 1'b1;
        w_ctrl.MDRin = 1'b1;
        w_next       = S_T2;
      end
      S_T2: begin
        w_run         = 1'b1;
        w_ctrl.MDRout = 1'b1;
        w_ctrl.IRin   = 1'b1;
        w_next        = S_T3;
      end
      S_T3: begin
        w_run = 1'b1;
        case (w_op)
          OP_BR: begin
            w_ctrl.Gra   = 1'b1;
            w_ctrl.Rout  = 1'b1;
            w_ctrl.CONin = 1'b1;
            w_next       = S_T4;
          end
          OP_ADDI: begin
            w_ctrl.Grb  = 1'b1;
            w_ctrl.Rout = 1'b1;
            w_ctrl.Yin  = 1'b1;
            w_next      = S_T4;
          end
          OP_LDI, OP_LD, OP_ST: begin
            w_ctrl.Grb   = 1'b1;
            w_ctrl.BAout = 1'b1;
            w_ctrl.Yin   = 1'b1;
            w_next       = S_T4;
          end
          OP_JR: begin
            w_ctrl.Gra  = 1'b1;
            w_ctrl.Rout = 1'b1;
            w_ctrl.PCin = 1'b1;
            w_next      = S_T0;
          end
          OP_HALT: begin
            w_next = S_HALT;
          end
          default: begin
            // nop and unassigned opcodes: one idle T3.
            w_next = S_T0;
          end
        endcase
      end
      S_T4: begin
        w_run = 1'b1;
        case (w_op)
          OP_BR: begin
            w_ctrl.PCout = 1'b1;
            w_ctrl.Yin   = 1'b1;
            w_next       = S_T5;
          end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
            w_ctrl.Cout = 1'b1;
            w_ctrl.ADD  = 1'b1;
            w_ctrl.Zin  = 1'b1;
            w_next      = S_T5;
          end
          default: begin
            w_next = S_T0;
          end
        endcase
      end
      S_T5: begin
        w_run = 1'b1;
        case (w_op)
          OP_BR: begin
            w_ctrl.Cout = 1'b1;
            w_ctrl.ADD  = 1'b1;
            w_ctrl.Zin  = 1'b1;
            w_next      = S_T6;
          end
          OP_ADDI, OP_LDI: begin
            w_ctrl.Zlowout = 1'b1;
            w_ctrl.Gra     = 1'b1;
            w_ctrl.Rin     = 1'b1;
            w_next         = S_T0;
          end
          OP_LD, OP_ST: begin
            w_ctrl.Zlowout = 1'b1;
            w_ctrl.MARin   = 1'b1;
            w_next         = S_T6;
          end
          default: begin
            w_next = S_T0;
          end
        endcase
      end
      S_T6: begin
        w_run = 1'b1;
        case (w_op)
          OP_BR: begin
            w_ctrl.Zlowout = 1'b1;
            w_ctrl.PCin    = bus.CON;
            w_next         = S_T0;
          end
          OP_LD: begin
            w_ctrl.Read  = 1'b1;
            w_ctrl.MDRin = 1'b1;
            w_next       = S_T7;
          end
          OP_ST: begin
            w_ctrl.Gra   = 1'b1;
            w_ctrl.Rout  = 1'b1;
            w_ctrl.MDRin = 1'b1;
            w_next       = S_T7;
          end
          default: begin
            w_next = S_T0;
          end
        endcase
      end
      S_T7: begin
        w_run = 1'b1;
        case (w_op)
          OP_LD: begin
            w_ctrl.MDRout = 1'b1;
            w_ctrl.Gra    = 1'b1;
            w_ctrl.Rin    = 1'b1;
          end
          OP_ST: begin
            w_ctrl.Write = 1'b1;
          end
          default: begin
            w_ctrl = '0;
          end
        endcase
        w_next = S_T0;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_RST;
      end
    endcase
  end

  assign bus.Run     = w_run;
  assign bus.PCout   = w_ctrl.PCout;
  assign bus.MARin   = w_ctrl.MARin;
  assign bus.IncPC   = w_ctrl.IncPC;
  assign bus.PCin    = w_ctrl.PCin;
  assign bus.Read    = w_ctrl.Read;
  assign bus.Write   = w_ctrl.Write;
  assign bus.MDRin   = w_ctrl.MDRin;
  assign bus.MDRout  = w_ctrl.MDRout;
  assign bus.IRin    = w_ctrl.IRin;
  assign bus.Yin     = w_ctrl.Yin;
  assign bus.Zin     = w_ctrl.Zin;
  assign bus.Zlowout = w_ctrl.Zlowout;
  assign bus.ADD     = w_ctrl.ADD;
  assign bus.Cout    = w_ctrl.Cout;
  assign bus.Gra     = w_ctrl.Gra;
  assign bus.Grb     = w_ctrl.Grb;
  assign bus.Rin     = w_ctrl.Rin;
  assign bus.Rout    = w_ctrl.Rout;
  assign bus.BAout   = w_ctrl.BAout;
  assign bus.CONin   = w_ctrl.CONin;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction pushes its expected
// per-clock strobe vectors, which are popped and compared on the falling edge.
module tb_control_sequencer;

  localparam logic [20:0] M_RUN    = 21'h100000;
  localparam logic [20:0] M_PCOUT  = 21'h080000;
  localparam logic [20:0] M_MARIN  = 21'h040000;
  localparam logic [20:0] M_INCPC  = 21'h020000;
  localparam logic [20:0] M_PCIN   = 21'h010000;
  localparam logic [20:0] M_READ   = 21'h008000;
  localparam logic [20:0] M_WRITE  = 21'h004000;
  localparam logic [20:0] M_MDRIN  = 21'h002000;
  localparam logic [20:0] M_MDROUT = 21'h001000;
  localparam logic [20:0] M_IRIN   = 21'h000800;
  localparam logic [20:0] M_YIN    = 21'h000400;
  localparam logic [20:0] M_ZIN    = 21'h000200;
  localparam logic [20:0] M_ZLOW   = 21'h000100;
  localparam logic [20:0] M_ADD    = 21'h000080;
  localparam logic [20:0] M_COUT   = 21'h000040;
  localparam logic [20:0] M_GRA    = 21'h000020;
  localparam logic [20:0] M_GRB    = 21'h000010;
  localparam logic [20:0] M_RIN    = 21'h000008;
  localparam logic [20:0] M_ROUT   = 21'h000004;
  localparam logic [20:0] M_BAOUT  = 21'h000002;
  localparam logic [20:0] M_CONIN  = 21'h000001;

  localparam logic [4:0] C_LD   = 5'b00000;
  localparam logic [4:0] C_LDI  = 5'b00001;
  localparam logic [4:0] C_ST   = 5'b00010;
  localparam logic [4:0] C_ADDI = 5'b01100;
  localparam logic [4:0] C_BR   = 5'b10010;
  localparam logic [4:0] C_JR   = 5'b10100;
  localparam logic [4:0] C_NOP  = 5'b11010;
  localparam logic [4:0] C_HALT = 5'b11011;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_fail;
  logic [20:0] sb[$];
  logic [20:0] obs;

  control_sequencer_if ifc();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  assign obs = {ifc.Run, ifc.PCout, ifc.MARin, ifc.IncPC, ifc.PCin, ifc.Read,
                ifc.Write, ifc.MDRin, ifc.MDRout, ifc.IRin, ifc.Yin, ifc.Zin,
                ifc.Zlowout, ifc.ADD, ifc.Cout, ifc.Gra, ifc.Grb, ifc.Rin,
                ifc.Rout, ifc.BAout, ifc.CONin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected strobe vector for clock number 'step' (0 = T0) of instruction 'op'.
  function automatic logic [20:0] exp_vec(input logic [4:0] op, input int step, input bit con);
    logic [20:0] v;
    v = M_RUN;
    if (step == 0)      v |= M_PCOUT | M_MARIN | M_INCPC;
    else if (step == 1) v |= M_READ | M_MDRIN;
    else if (step == 2) v |= M_MDROUT | M_IRIN;
    else if (op == C_BR) begin
      if (step == 3) v |= M_GRA | M_ROUT | M_CONIN;
      if (step == 4) v |= M_PCOUT | M_YIN;
      if (step == 5) v |= M_COUT | M_ADD | M_ZIN;
      if (step == 6) v |= M_ZLOW | (con ? M_PCIN : 21'h0);
    end else if (op == C_ADDI || op == C_LDI) begin
      if (step == 3) v |= M_GRB | M_YIN | ((op == C_ADDI) ? M_ROUT : M_BAOUT);
      if (step == 4) v |= M_COUT | M_ADD | M_ZIN;
      if (step == 5) v |= M_ZLOW | M_GRA | M_RIN;
    end else if (op == C_LD || op == C_ST) begin
      if (step == 3) v |= M_GRB | M_BAOUT | M_YIN;
      if (step == 4) v |= M_COUT | M_ADD | M_ZIN;
      if (step == 5) v |= M_ZLOW | M_MARIN;
      if (step == 6) v |= (op == C_LD) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
      if (step == 7) v |= (op == C_LD) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
    end else if (op == C_JR) begin
      if (step == 3) v |= M_GRA | M_ROUT | M_PCIN;
    end
    return v;
  endfunction

  function automatic int instr_len(input logic [4:0] op);
    if (op == C_LD || op == C_ST)        return 8;
    else if (op == C_BR)                 return 7;
    else if (op == C_ADDI || op == C_LDI) return 6;
    else                                 return 4;
  endfunction

  function automatic int drivers(input logic [20:0] v);
    return int'(v[19]) + int'(v[12]) + int'(v[8]) + int'(v[2]) + int'(v[1]) + int'(v[6]);
  endfunction

  // Runs 'nsteps' clocks of 'op' starting in T0; scramble changes IR after T3.
  task automatic run_instr(input logic [4:0] op, input bit con, input bit scramble, input int nsteps);
    logic [20:0] want;
    for (int s = 0; s < nsteps; s++) sb.push_back(exp_vec(op, s, con));
    for (int s = 0; s < nsteps; s++) begin
      ifc.opcode = (scramble && s > 3) ? 5'($urandom_range(0, 31)) : op;
      ifc.CON    = (s == 6) ? con : ~con;
      @(negedge clk);
      if (sb.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        want = sb.pop_front();
        check_eq($sformatf("op%05b_T%0d", op, s), {11'd0, obs}, {11'd0, want});
      end
      check_eq("bus_drivers_le1", 32'(drivers(obs) > 1), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse clr low for a cycle and step through RST into T0.
  task automatic clr_pulse();
    clr = 1'b0;
    #1;
    check_eq("async_clr_outs", {11'd0, obs}, 32'd0);
    @(negedge clk);
    check_eq("clr_held_outs", {11'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check_eq("rst_state_outs", {11'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    clr        = 1'b1;
    ifc.opcode = 5'd0;
    ifc.CON    = 1'b0;
    #2 clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {11'd0, obs}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check_eq("rst_idle_outs", {11'd0, obs}, 32'd0);
    @(posedge clk);
    #1;

    run_instr(C_LD,   1'b0, 1'b1, instr_len(C_LD));
    run_instr(C_ST,   1'b1, 1'b1, instr_len(C_ST));
    run_instr(C_BR,   1'b1, 1'b1, instr_len(C_BR));
    run_instr(C_BR,   1'b0, 1'b0, instr_len(C_BR));
    run_instr(C_ADDI, 1'b0, 1'b1, instr_len(C_ADDI));
    run_instr(C_LDI,  1'b1, 1'b0, instr_len(C_LDI));
    run_instr(C_JR,   1'b0, 1'b1, instr_len(C_JR));
    run_instr(C_NOP,  1'b0, 1'b0, instr_len(C_NOP));
    run_instr(5'b11111, 1'b0, 1'b0, instr_len(5'b11111));
    run_instr(5'b00111, 1'b1, 1'b0, instr_len(5'b00111));
    run_instr(C_LD,   1'b1, 1'b0, instr_len(C_LD));

    // halt: T0-T3 then 20 idle clocks with Run low.
    run_instr(C_HALT, 1'b0, 1'b0, instr_len(C_HALT));
    for (int i = 0; i < 20; i++) sb.push_back(21'h0);
    for (int i = 0; i < 20; i++) begin
      ifc.opcode = 5'($urandom_range(0, 31));
      @(negedge clk);
      check_eq($sformatf("halt_idle_%0d", i), {11'd0, obs}, {11'd0, sb.pop_front()});
      @(posedge clk);
      #1;
    end
    clr_pulse();
    run_instr(C_JR, 1'b1, 1'b0, instr_len(C_JR));

    // addi interrupted in T5: Rin must never reach the bus once clr is low.
    run_instr(C_ADDI, 1'b0, 1'b0, 5);
    #1;
    clr_pulse();
    check_eq("rin_after_clr", {31'd0, ifc.Rin}, 32'd0);
    run_instr(C_NOP,  1'b0, 1'b0, instr_len(C_NOP));
    run_instr(C_ADDI, 1'b0, 1'b0, instr_len(C_ADDI));

    // A few random opcodes back to back.
    for (int k = 0; k < 6; k++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == C_HALT) op = C_NOP;
      run_instr(op, 1'($urandom_range(0, 1)), 1'b1, instr_len(op));
    end

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
